ramp_sweep_gen: RTL and testbench
=================================

Name: ramp_sweep_gen

Overview:
- Parametrised successor to the single-mode ramp generator that feeds the DAC serializer and indexes the ADC capture RAM.
- Produces a DAC code sequence in one of four modes: DC, sawtooth-up, sawtooth-down, triangle.
- Each point lasts a programmable number of cycles; a sweep can repeat N times or run continuously.
- Emits a DAC-load pulse, an ADC sample strobe and a per-sweep capture address for the RAM controller.

Parameters:
DATA_W, 16, DAC code width (ramp_out, set_min, set_max, step, dc_value)
ADDR_W, 16, capture address / point index width
DLY_W, 6, point-period counter width
CNT_W, 8, sweep-repeat counter width

Ports:
clk  in  1  system clock, the only clock
rst  in  1  asynchronous, active-low reset
trig  in  1  one-cycle start pulse
abort  in  1  stop request, level-sampled
mode  in  2  00 DC, 01 saw-up, 10 triangle, 11 saw-down
set_min  in  DATA_W  lower bound
set_max  in  DATA_W  upper bound
step  in  DATA_W  increment per point
dc_value  in  DATA_W  DC-mode output code
dc_len  in  ADDR_W  points per sweep in DC mode (0 treated as 1)
point_period  in  DLY_W  cycles per point (values <2 treated as 2)
sweeps  in  CNT_W  sweep count (0 = continuous until abort)
ramp_out  out  DATA_W  current DAC code
dac_load  out  1  pulse, first cycle of each point
sample_stb  out  1  pulse, last cycle of each point
wr_addr  out  ADDR_W  point index within the current sweep, valid with sample_stb
busy  out  1  high while running
done  out  1  one-cycle pulse at normal completion
cfg_err  out  1  sticky configuration error flag

Behaviour:
- Reset (rst=0, async): state IDLE; ramp_out=0, wr_addr=0, all pulses 0, busy=0, cfg_err=0.
- States:
  - IDLE -> RUN on trig with a valid configuration.
  - RUN -> DONE after the last point of the last sweep.
  - DONE -> IDLE after one cycle.
  - abort in RUN -> IDLE on the next edge.
- Configuration latch: all config inputs are latched on trig in IDLE. Later input changes do not affect the current run. trig outside IDLE is ignored.
- Invalid configuration, checked on trig in non-DC modes: set_min>set_max or step==0.
  - Run is not started; cfg_err set to 1.
  - cfg_err stays 1 until the next valid trig clears it.
- Start timing: trig at cycle T, then at T+1 ramp_out=first point, dac_load=1, busy=1.
- Point timing:
  - Each point holds for P=max(point_period,2) cycles.
  - sample_stb is asserted in cycle P of the point, with wr_addr equal to the point index.
  - The next point loads on the following cycle.
- Sequences (arithmetic done in DATA_W+1 bits; no wrap-around is ever output):
  - saw-up: min, min+step, ... while value ≤ max. The sweep ends when cur+step > max.
  - saw-down: max, max-step, ... while value ≥ min. The sweep ends when cur-step < min, including underflow.
  - triangle: rises as in saw-up. At the first point where cur+step > max it turns and emits cur-step, cur-2·step, ... while value ≥ min. The peak point is not repeated.
  - DC: dc_value for max(dc_len,1) points per sweep.
- Sweep repetition:
  - Each new sweep restarts from its first point, i.e. min, or max for saw-down.
  - wr_addr restarts at 0 at every sweep start.
  - With sweeps=0, sweeping repeats until abort.
- Completion: the cycle after the final sample_stb, done=1 for 1 cycle, busy=0, and ramp_out holds the last code.
- abort:
  - Takes effect on the next edge; abort wins over trig in the same cycle.
  - busy drops to 0, no done pulse, no further strobes.
  - ramp_out holds its value and wr_addr holds.
- Async reset mid-run: immediate return to reset values. No done is generated.

Test Plan:
- Saw-up: mode=01, min=0, max=10, step=4, P=3, sweeps=1, trig at T -> ramp_out 0/4/8 from T+1/T+4/T+7; sample_stb at T+3/T+6/T+9 with wr_addr 0/1/2; done at T+10; busy low from T+10.
- Triangle, same configuration, sweeps=2 -> codes 0,4,8,4,0,0,4,8,4,0; wr_addr runs 0..4 twice; 10 sample_stb pulses; a single done.
- Saw-down: mode=11, min=3, max=12, step=5 -> 12,7 then end (cur-step=2<3). Overflow edge: saw-up, min=0, max=0xFFFF, step=0x8000 -> 0, 0x8000 only, no wrapped code.
- Config error: min=20, max=10 -> cfg_err=1, busy stays 0, no dac_load. A subsequent valid trig -> cfg_err clears and the run starts.
- DC: mode=00, dc_value=0x1234, dc_len=0, sweeps=3 -> 3 points of 0x1234, each with wr_addr=0; done after the 3rd sample_stb.
- Continuous saw-up with sweeps=0, abort asserted mid-point -> busy=0 next cycle, no done, ramp_out held. Assert rst=0 mid-run -> outputs go to reset values immediately, asynchronously.

Source files
------------

// File: rtl/ramp_sweep_gen.sv
// Ramp/sweep DAC code generator with per-point DAC load, ADC sample strobe and capture address.
// Latency: first point one cycle after trig; each point holds max(point_period,2) cycles.
// Backpressure: none, free-running once started; abort stops on the next edge.
module ramp_sweep_gen #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DLY_W  = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] set_min,
    input  logic [DATA_W-1:0] set_max,
    input  logic [DATA_W-1:0] step,
    input  logic [DATA_W-1:0] dc_value,
    input  logic [ADDR_W-1:0] dc_len,
    input  logic [DLY_W-1:0]  point_period,
    input  logic [CNT_W-1:0]  sweeps,
    output logic [DATA_W-1:0] ramp_out,
    output logic              dac_load,
    output logic              sample_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_DC  = 2'b00;
    localparam logic [1:0] M_UP  = 2'b01;
    localparam logic [1:0] M_TRI = 2'b10;
    localparam logic [1:0] M_DN  = 2'b11;

    logic [1:0]        state;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] min_q, max_q, step_q, dcv_q;
    logic [ADDR_W-1:0] dc_len_q;
    logic [DLY_W-1:0]  period_q;
    logic [CNT_W-1:0]  sweeps_q, sweep_left;
    logic [DLY_W-1:0]  cnt;
    logic              dn_phase;
    logic [DATA_W-1:0] ramp_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cfg_err_q;

    logic              cfg_bad;
    logic [DATA_W-1:0] start_val, first_val, nxt_val;
    logic [DATA_W:0]   sum_w, diff_w;
    logic [ADDR_W:0]   addr_inc;
    logic              up_ok, dn_ok, nxt_ok, nxt_dn;
    logic              last_point, last_sweep;

    always_comb begin
        cfg_bad = (mode != M_DC) && ((set_min > set_max) || (step == '0));

        case (mode)
            M_DC:    start_val = dc_value;
            M_DN:    start_val = set_max;
            default: start_val = set_min;
        endcase

        case (mode_q)
            M_DC:    first_val = dcv_q;
            M_DN:    first_val = max_q;
            default: first_val = min_q;
        endcase

        // One extra bit so neither overflow past max nor underflow below 0 can alias a legal code.
        sum_w    = {1'b0, ramp_q} + {1'b0, step_q};
        diff_w   = {1'b0, ramp_q} - {1'b0, step_q};
        up_ok    = sum_w <= {1'b0, max_q};
        dn_ok    = !diff_w[DATA_W] && (diff_w[DATA_W-1:0] >= min_q);
        addr_inc = {1'b0, addr_q} + (ADDR_W+1)'(1);

        nxt_val = sum_w[DATA_W-1:0];
        nxt_ok  = 1'b0;
        nxt_dn  = 1'b0;
        case (mode_q)
            M_DC: begin
                nxt_val = dcv_q;
                nxt_ok  = addr_inc < {1'b0, dc_len_q};
            end
            M_UP: begin
                nxt_ok = up_ok;
            end
            M_DN: begin
                nxt_val = diff_w[DATA_W-1:0];
                nxt_ok  = dn_ok;
            end
            default: begin
                if (!dn_phase && up_ok) begin
                    nxt_ok = 1'b1;
                end else begin
                    nxt_val = diff_w[DATA_W-1:0];
                    nxt_ok  = dn_ok;
                    nxt_dn  = 1'b1;
                end
            end
        endcase

        last_point = (cnt == period_q);
        last_sweep = (sweeps_q != '0) && (sweep_left == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            mode_q     <= M_DC;
            min_q      <= '0;
            max_q      <= '0;
            step_q     <= '0;
            dcv_q      <= '0;
            dc_len_q   <= '0;
            period_q   <= '0;
            sweeps_q   <= '0;
            sweep_left <= '0;
            cnt        <= '0;
            dn_phase   <= 1'b0;
            ramp_q     <= '0;
            addr_q     <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trig && !abort) begin
                        if (cfg_bad) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            cfg_err_q  <= 1'b0;
                            state      <= S_RUN;
                            mode_q     <= mode;
                            min_q      <= set_min;
                            max_q      <= set_max;
                            step_q     <= step;
                            dcv_q      <= dc_value;
                            dc_len_q   <= (dc_len == '0) ? ADDR_W'(1) : dc_len;
                            period_q   <= (point_period < DLY_W'(2)) ? DLY_W'(2) : point_period;
                            sweeps_q   <= sweeps;
                            sweep_left <= sweeps;
                            ramp_q     <= start_val;
                            addr_q     <= '0;
                            cnt        <= DLY_W'(1);
                            dn_phase   <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (!last_point) begin
                        cnt <= cnt + DLY_W'(1);
                    end else if (nxt_ok) begin
                        ramp_q   <= nxt_val;
                        addr_q   <= addr_q + ADDR_W'(1);
                        dn_phase <= nxt_dn;
                        cnt      <= DLY_W'(1);
                    end else if (last_sweep) begin
                        state <= S_DONE;
                    end else begin
                        ramp_q   <= first_val;
                        addr_q   <= '0;
                        dn_phase <= 1'b0;
                        cnt      <= DLY_W'(1);
                        if (sweeps_q != '0) begin
                            sweep_left <= sweep_left - CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ramp_out   = ramp_q;
    assign wr_addr    = addr_q;
    assign busy       = (state == S_RUN);
    assign done       = (state == S_DONE);
    assign dac_load   = busy && (cnt == DLY_W'(1));
    assign sample_stb = busy && last_point;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_ramp_sweep_gen.sv
// Scoreboard bench for ramp_sweep_gen: a loop-based sequence model queues expected samples.
module tb_ramp_sweep_gen;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DLY_W  = 6;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              trig;
    logic              abort;
    logic [1:0]        mode;
    logic [DATA_W-1:0] set_min, set_max, step, dc_value;
    logic [ADDR_W-1:0] dc_len;
    logic [DLY_W-1:0]  point_period;
    logic [CNT_W-1:0]  sweeps;
    logic [DATA_W-1:0] ramp_out;
    logic              dac_load, sample_stb, busy, done, cfg_err;
    logic [ADDR_W-1:0] wr_addr;

    ramp_sweep_gen #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DLY_W(DLY_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .trig(trig), .abort(abort), .mode(mode),
        .set_min(set_min), .set_max(set_max), .step(step), .dc_value(dc_value),
        .dc_len(dc_len), .point_period(point_period), .sweeps(sweeps),
        .ramp_out(ramp_out), .dac_load(dac_load), .sample_stb(sample_stb),
        .wr_addr(wr_addr), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] code;
        logic [15:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_stb = 0;
    int   n_load = 0;
    int   n_done = 0;
    bit   sb_en = 1'b1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (dac_load) n_load++;
            if (done) n_done++;
            if (sample_stb) begin
                n_stb++;
                if (sb_en) begin
                    if (exp_q.size() == 0) begin
                        check_val("extra_stb", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check_val("stb_code", 32'(ramp_out), 32'(mon_e.code));
                        check_val("stb_addr", 32'(wr_addr), 32'(mon_e.addr));
                    end
                end
            end
        end
    end

    // Reference sequence built by plain integer loops, one entry per sample strobe.
    task automatic push_model(input logic [1:0] m, input int mn, input int mx, input int st,
                              input int dcv, input int dcl, input int sw);
        int v, last, a, n;
        for (int s = 0; s < sw; s++) begin
            a = 0;
            case (m)
                2'b00: begin
                    n = (dcl == 0) ? 1 : dcl;
                    for (int i = 0; i < n; i++) begin
                        exp_q.push_back(exp_t'({dcv[15:0], a[15:0]})); a++;
                    end
                end
                2'b01: begin
                    v = mn;
                    while (v <= mx) begin exp_q.push_back(exp_t'({v[15:0], a[15:0]})); a++; v += st; end
                end
                2'b11: begin
                    v = mx;
                    while (v >= mn) begin exp_q.push_back(exp_t'({v[15:0], a[15:0]})); a++; v -= st; end
                end
                default: begin
                    v = mn;
                    last = mn;
                    while (v <= mx) begin exp_q.push_back(exp_t'({v[15:0], a[15:0]})); a++; last = v; v += st; end
                    v = last - st;
                    while (v >= mn) begin exp_q.push_back(exp_t'({v[15:0], a[15:0]})); a++; v -= st; end
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] m, input int mn, input int mx, input int st,
                           input int pp, input int sw);
        mode         = m;
        set_min      = mn[15:0];
        set_max      = mx[15:0];
        step         = st[15:0];
        point_period = pp[DLY_W-1:0];
        sweeps       = sw[CNT_W-1:0];
    endtask

    task automatic fire();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int base;
        int k;
        base = n_done;
        k = 0;
        while (n_done == base && k < lim) begin
            tick();
            k++;
        end
        repeat (4) tick();
        check_val(tag, n_done - base, 1);
        check_val({tag, "_qempty"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base_stb, base_load, base_done;
        int k;
        logic [DATA_W-1:0] held;

        rst = 1'b0; trig = 1'b0; abort = 1'b0;
        dc_value = '0; dc_len = '0;
        set_cfg(2'b00, 0, 0, 0, 0, 0);
        tick(); tick();
        check_val("rst_ramp", 32'(ramp_out), 0);
        check_val("rst_addr", 32'(wr_addr), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_done", 32'(done), 0);
        check_val("rst_pulses", {30'd0, dac_load, sample_stb}, 0);
        check_val("rst_cfg_err", 32'(cfg_err), 0);
        rst = 1'b1;
        tick();

        // Saw-up with cycle-exact timing around trig at cycle T.
        set_cfg(2'b01, 0, 10, 4, 3, 1);
        push_model(2'b01, 0, 10, 4, 0, 0, 1);
        base_done = n_done;
        fire();
        for (int c = 1; c <= 12; c++) begin
            check_val("t1_ramp", 32'(ramp_out), (c < 4) ? 0 : (c < 7) ? 4 : 8);
            check_val("t1_load", 32'(dac_load), (c == 1 || c == 4 || c == 7) ? 1 : 0);
            check_val("t1_stb", 32'(sample_stb), (c == 3 || c == 6 || c == 9) ? 1 : 0);
            check_val("t1_done", 32'(done), (c == 10) ? 1 : 0);
            check_val("t1_busy", 32'(busy), (c <= 9) ? 1 : 0);
            tick();
        end
        check_val("t1_done_cnt", n_done - base_done, 1);
        check_val("t1_qempty", exp_q.size(), 0);

        // Triangle, two sweeps; a mid-run trig with other settings must be ignored.
        set_cfg(2'b10, 0, 10, 4, 3, 2);
        push_model(2'b10, 0, 10, 4, 0, 0, 2);
        base_stb = n_stb;
        fire();
        tick(); tick();
        set_cfg(2'b00, 1, 2, 1, 5, 1);
        fire();
        wait_done("t2_done", 100);
        check_val("t2_stb_cnt", n_stb - base_stb, 10);

        set_cfg(2'b11, 3, 12, 5, 2, 1);
        push_model(2'b11, 3, 12, 5, 0, 0, 1);
        fire();
        wait_done("t3_down", 50);

        set_cfg(2'b01, 0, 16'hFFFF, 16'h8000, 2, 1);
        push_model(2'b01, 0, 16'hFFFF, 16'h8000, 0, 0, 1);
        base_stb = n_stb;
        fire();
        wait_done("t4_ovf", 50);
        check_val("t4_stb_cnt", n_stb - base_stb, 2);

        // Invalid configuration, then a valid trig clears the flag.
        set_cfg(2'b01, 20, 10, 1, 2, 1);
        base_load = n_load;
        fire();
        tick(); tick();
        check_val("t5_cfg_err", 32'(cfg_err), 1);
        check_val("t5_busy", 32'(busy), 0);
        check_val("t5_no_load", n_load - base_load, 0);
        set_cfg(2'b01, 0, 10, 4, 2, 1);
        push_model(2'b01, 0, 10, 4, 0, 0, 1);
        fire();
        check_val("t5_cfg_clr", 32'(cfg_err), 0);
        check_val("t5_busy_run", 32'(busy), 1);
        wait_done("t5_done", 50);

        // DC with dc_len=0 and a bad min/max/step that DC must not flag.
        set_cfg(2'b00, 20, 10, 0, 0, 3);
        dc_value = 16'h1234;
        dc_len   = '0;
        push_model(2'b00, 0, 0, 0, 16'h1234, 0, 3);
        base_stb = n_stb;
        fire();
        check_val("t6_cfg_err", 32'(cfg_err), 0);
        wait_done("t6_dc", 50);
        check_val("t6_stb_cnt", n_stb - base_stb, 3);

        // Continuous saw-up, abort in the middle of the 8th point.
        set_cfg(2'b01, 0, 10, 4, 3, 0);
        push_model(2'b01, 0, 10, 4, 0, 0, 3);
        base_load = n_load;
        base_done = n_done;
        fire();
        k = 0;
        while (n_load - base_load < 8 && k < 200) begin
            tick();
            k++;
        end
        check_val("t7_loads", n_load - base_load, 8);
        check_val("t7_busy_pre", 32'(busy), 1);
        held = ramp_out;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("t7_busy", 32'(busy), 0);
        check_val("t7_ramp", 32'(ramp_out), 4);
        check_val("t7_held", 32'(ramp_out), 32'(held));
        check_val("t7_addr", 32'(wr_addr), 1);
        base_stb = n_stb;
        repeat (6) tick();
        check_val("t7_no_stb", n_stb - base_stb, 0);
        check_val("t7_no_done", n_done - base_done, 0);
        check_val("t7_ramp_hold", 32'(ramp_out), 4);
        exp_q.delete();

        // abort beats trig in the same cycle.
        abort = 1'b1;
        fire();
        abort = 1'b0;
        check_val("t8_abort_trig", 32'(busy), 0);

        // Asynchronous reset in the middle of a run.
        sb_en = 1'b0;
        set_cfg(2'b01, 5, 100, 7, 3, 1);
        base_done = n_done;
        fire();
        repeat (4) tick();
        check_val("t9_busy_pre", 32'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        check_val("t9_ramp", 32'(ramp_out), 0);
        check_val("t9_addr", 32'(wr_addr), 0);
        check_val("t9_busy", 32'(busy), 0);
        check_val("t9_pulses", {30'd0, dac_load, sample_stb}, 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        check_val("t9_no_done", n_done - base_done, 0);
        check_val("t9_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
